// File: rtl/pkg_cpu.sv
// Shared CPU definitions: word/flag/opcode widths, flag bit positions,
// ALU operation encoding and the ALU issue controller state encoding.
package pkg_cpu;

  localparam int WORD_WIDTH    = 32;
  localparam int FLAGS_WIDTH   = 4;
  localparam int OPER_WIDTH    = 5;
  localparam int REG_IDX_WIDTH = 4;

  typedef enum logic [1:0] {
    FlagZ = 2'd0,
    FlagC = 2'd1,
    FlagV = 2'd2,
    FlagN = 2'd3
  } flag_idx_e;

  typedef enum logic [OPER_WIDTH-1:0] {
    Alu_Add = 5'd0,
    Alu_Adc = 5'd1,
    Alu_Sub = 5'd2,
    Alu_Sbc = 5'd3,
    Alu_And = 5'd4,
    Alu_Or  = 5'd5,
    Alu_Xor = 5'd6,
    Alu_Not = 5'd7,
    Alu_Shl = 5'd8,
    Alu_Shr = 5'd9,
    Alu_Sar = 5'd10,
    Alu_Mov = 5'd11,
    Alu_Mac = 5'd12
  } alu_oper_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } st_alu_issue;

  function automatic logic [FLAGS_WIDTH-1:0] pack_flags(
    input logic z, input logic c, input logic v, input logic n);
    logic [FLAGS_WIDTH-1:0] f;
    f        = '0;
    f[FlagZ] = z;
    f[FlagC] = c;
    f[FlagV] = v;
    f[FlagN] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: out/flags_out from a, b, c, oper and incoming flags.
// Zero latency; no flow control. C is carry-out for add, not-borrow for subtract.
module alu
  import pkg_cpu::*;
#(
  parameter int WORD_WIDTH  = pkg_cpu::WORD_WIDTH,
  parameter int FLAGS_WIDTH = pkg_cpu::FLAGS_WIDTH,
  parameter int OPER_WIDTH  = pkg_cpu::OPER_WIDTH
) (
  input  logic [WORD_WIDTH-1:0]  i_a,
  input  logic [WORD_WIDTH-1:0]  i_b,
  input  logic [WORD_WIDTH-1:0]  i_c,
  input  logic [OPER_WIDTH-1:0]  i_oper,
  input  logic [FLAGS_WIDTH-1:0] i_flags_in,
  output logic [WORD_WIDTH-1:0]  o_out,
  output logic [FLAGS_WIDTH-1:0] o_flags_out
);

  localparam int SHW = $clog2(WORD_WIDTH);
  localparam int MSB = WORD_WIDTH - 1;

  logic [WORD_WIDTH:0]   w_sum;
  logic [WORD_WIDTH-1:0] w_res;
  logic                  w_c;
  logic                  w_v;

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_oper)
      Alu_Add, Alu_Adc: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b}
              + {{WORD_WIDTH{1'b0}}, (i_oper == Alu_Adc) & i_flags_in[FlagC]};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WORD_WIDTH];
        w_v   = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      Alu_Sub, Alu_Sbc: begin
        // Two's complement subtract: carry-in is 1 for Sub, current C for Sbc.
        w_sum = {1'b0, i_a} + {1'b0, ~i_b}
              + {{WORD_WIDTH{1'b0}}, (i_oper == Alu_Sub) | i_flags_in[FlagC]};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WORD_WIDTH];
        w_v   = (i_a[MSB] != i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
      end
      Alu_And: w_res = i_a & i_b;
      Alu_Or:  w_res = i_a | i_b;
      Alu_Xor: w_res = i_a ^ i_b;
      Alu_Not: w_res = ~i_a;
      Alu_Shl: w_res = i_a << i_b[SHW-1:0];
      Alu_Shr: w_res = i_a >> i_b[SHW-1:0];
      Alu_Sar: w_res = $signed(i_a) >>> i_b[SHW-1:0];
      Alu_Mov: w_res = i_b;
      Alu_Mac: w_res = i_a * i_b + i_c;
      default: w_res = '0;
    endcase
  end

  assign o_out       = w_res;
  assign o_flags_out = pack_flags(w_res == '0, w_c, w_v, w_res[MSB]);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accept, RF read, execute, write back (3 cycles to rf_wr_en, 1 op per 4).
// Optional `ALU_ISSUE_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module alu_issue_ctrl
  import pkg_cpu::*;
#(
  parameter int WORD_WIDTH    = pkg_cpu::WORD_WIDTH,
  parameter int FLAGS_WIDTH   = pkg_cpu::FLAGS_WIDTH,
  parameter int OPER_WIDTH    = pkg_cpu::OPER_WIDTH,
  parameter int REG_IDX_WIDTH = pkg_cpu::REG_IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPER_WIDTH-1:0]    in_oper,
  input  logic [REG_IDX_WIDTH-1:0] in_ra_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_rb_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_rc_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_rd_idx,
  input  logic                     in_use_imm,
  input  logic [WORD_WIDTH-1:0]    in_imm,
  input  logic                     in_wr_flags,
  output logic [REG_IDX_WIDTH-1:0] rf_rd_idx_a,
  output logic [REG_IDX_WIDTH-1:0] rf_rd_idx_b,
  output logic [REG_IDX_WIDTH-1:0] rf_rd_idx_c,
  input  logic [WORD_WIDTH-1:0]    rf_rd_data_a,
  input  logic [WORD_WIDTH-1:0]    rf_rd_data_b,
  input  logic [WORD_WIDTH-1:0]    rf_rd_data_c,
  output logic [WORD_WIDTH-1:0]    alu_a,
  output logic [WORD_WIDTH-1:0]    alu_b,
  output logic [WORD_WIDTH-1:0]    alu_c,
  output logic [OPER_WIDTH-1:0]    alu_oper,
  output logic [FLAGS_WIDTH-1:0]   alu_flags_in,
  input  logic [WORD_WIDTH-1:0]    alu_out,
  input  logic [FLAGS_WIDTH-1:0]   alu_flags_out,
  output logic                     rf_wr_en,
  output logic [REG_IDX_WIDTH-1:0] rf_wr_idx,
  output logic [WORD_WIDTH-1:0]    rf_wr_data,
  output logic [FLAGS_WIDTH-1:0]   flags,
  output logic                     busy
);

  st_alu_issue r_state;
  st_alu_issue w_state_nxt;

  logic [OPER_WIDTH-1:0]    r_oper;
  logic [REG_IDX_WIDTH-1:0] r_ra;
  logic [REG_IDX_WIDTH-1:0] r_rb;
  logic [REG_IDX_WIDTH-1:0] r_rc;
  logic [REG_IDX_WIDTH-1:0] r_rd;
  logic                     r_use_imm;
  logic [WORD_WIDTH-1:0]    r_imm;
  logic                     r_wr_flags;
  logic [WORD_WIDTH-1:0]    r_res_data;
  logic [FLAGS_WIDTH-1:0]   r_res_flags;
  logic [FLAGS_WIDTH-1:0]   r_flags;
  logic [WORD_WIDTH-1:0]    r_alu_a;
  logic [WORD_WIDTH-1:0]    r_alu_b;
  logic [WORD_WIDTH-1:0]    r_alu_c;

  logic                     w_accept;
  logic                     w_exec;
  logic                     w_wb;
  logic                     w_wr_allowed;
  logic [WORD_WIDTH-1:0]    w_a_exec;
  logic [WORD_WIDTH-1:0]    w_b_exec;
  logic [WORD_WIDTH-1:0]    w_c_exec;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_exec      = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = READ;
      end
      READ: w_state_nxt = EXEC;
      EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = WB;
      end
      WB: begin
        w_wb        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

`ifdef ALU_ISSUE_ZERO_REG_EN
  assign w_a_exec     = (r_ra == '0) ? '0 : rf_rd_data_a;
  assign w_b_exec     = r_use_imm ? r_imm : ((r_rb == '0) ? '0 : rf_rd_data_b);
  assign w_c_exec     = (r_rc == '0) ? '0 : rf_rd_data_c;
  assign w_wr_allowed = (r_rd != '0);
`else
  assign w_a_exec     = rf_rd_data_a;
  assign w_b_exec     = r_use_imm ? r_imm : rf_rd_data_b;
  assign w_c_exec     = rf_rd_data_c;
  assign w_wr_allowed = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_oper      <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      r_rd        <= '0;
      r_use_imm   <= 1'b0;
      r_imm       <= '0;
      r_wr_flags  <= 1'b0;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_flags     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_oper     <= in_oper;
        r_ra       <= in_ra_idx;
        r_rb       <= in_rb_idx;
        r_rc       <= in_rc_idx;
        r_rd       <= in_rd_idx;
        r_use_imm  <= in_use_imm;
        r_imm      <= in_imm;
        r_wr_flags <= in_wr_flags;
      end
      if (w_exec) begin
        r_res_data  <= alu_out;
        r_res_flags <= alu_flags_out;
        r_alu_a     <= w_a_exec;
        r_alu_b     <= w_b_exec;
        r_alu_c     <= w_c_exec;
      end
      if (w_wb && r_wr_flags) r_flags <= r_res_flags;
    end
  end

  // Operands pass straight through in EXEC and are held afterwards so the ALU never sees X.
  assign alu_a        = w_exec ? w_a_exec : r_alu_a;
  assign alu_b        = w_exec ? w_b_exec : r_alu_b;
  assign alu_c        = w_exec ? w_c_exec : r_alu_c;
  assign alu_oper     = r_oper;
  assign alu_flags_in = r_flags;

  assign rf_rd_idx_a  = r_ra;
  assign rf_rd_idx_b  = r_rb;
  assign rf_rd_idx_c  = r_rc;

  // A reset landing on the WB cycle aborts the op, so the strobe is suppressed too.
  assign rf_wr_en     = w_wb & w_wr_allowed & ~rst;
  assign rf_wr_idx    = r_rd;
  assign rf_wr_data   = r_res_data;

  assign flags        = r_flags;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with the real ALU and a 16x32 synchronous-read register file.
// Expected values are hand-computed; `ALU_ISSUE_ZERO_REG_EN selects the zero-register expectations.
module tb_alu_issue_ctrl;
  import pkg_cpu::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_oper = '0;
  logic [3:0]  in_ra_idx = '0, in_rb_idx = '0, in_rc_idx = '0, in_rd_idx = '0;
  logic        in_use_imm = 1'b0;
  logic [31:0] in_imm = '0;
  logic        in_wr_flags = 1'b0;
  logic [3:0]  rf_rd_idx_a, rf_rd_idx_b, rf_rd_idx_c;
  logic [31:0] rf_rd_data_a = '0, rf_rd_data_b = '0, rf_rd_data_c = '0;
  logic [31:0] alu_a, alu_b, alu_c, alu_out;
  logic [4:0]  alu_oper;
  logic [3:0]  alu_flags_in, alu_flags_out, flags;
  logic        rf_wr_en, busy;
  logic [3:0]  rf_wr_idx;
  logic [31:0] rf_wr_data;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_oper(in_oper), .in_ra_idx(in_ra_idx), .in_rb_idx(in_rb_idx),
    .in_rc_idx(in_rc_idx), .in_rd_idx(in_rd_idx), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .in_wr_flags(in_wr_flags),
    .rf_rd_idx_a(rf_rd_idx_a), .rf_rd_idx_b(rf_rd_idx_b), .rf_rd_idx_c(rf_rd_idx_c),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b), .rf_rd_data_c(rf_rd_data_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_oper(alu_oper),
    .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .flags(flags), .busy(busy)
  );

  alu u_alu (
    .i_a(alu_a), .i_b(alu_b), .i_c(alu_c), .i_oper(alu_oper),
    .i_flags_in(alu_flags_in), .o_out(alu_out), .o_flags_out(alu_flags_out)
  );

  // Register file model with a bench-side preload port; the DUT write has priority.
  logic [31:0] mem [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_widx = '0;
  logic [31:0] tb_wdat = '0;
  int          cyc = 0;
  int          wr_cnt = 0;
  logic [3:0]  wlog_idx [32];
  logic [31:0] wlog_dat [32];

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    rf_rd_data_a <= mem[rf_rd_idx_a];
    rf_rd_data_b <= mem[rf_rd_idx_b];
    rf_rd_data_c <= mem[rf_rd_idx_c];
    if (rf_wr_en) begin
      mem[rf_wr_idx]         <= rf_wr_data;
      wlog_idx[wr_cnt[4:0]]  <= rf_wr_idx;
      wlog_dat[wr_cnt[4:0]]  <= rf_wr_data;
      wr_cnt                 <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_widx] <= tb_wdat;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] dat);
    @(negedge clk);
    tb_we = 1'b1; tb_widx = idx; tb_wdat = dat;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic set_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rd, input logic ui, input logic [31:0] imm,
                           input logic wf);
    in_oper = op; in_ra_idx = ra; in_rb_idx = rb; in_rc_idx = 4'd0; in_rd_idx = rd;
    in_use_imm = ui; in_imm = imm; in_wr_flags = wf;
  endtask

  // Holds in_valid until in_ready is seen, then returns just after the accept edge.
  task automatic wait_accept(input string tag, output int acc_cyc);
    acc_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
    check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Runs one op over the fixed 4-cycle window; captures EXEC-cycle ALU signals.
  task automatic run_op(input string tag, output int lat, output logic [31:0] ex_a,
                        output logic [3:0] ex_fin, output logic [3:0] ex_fout);
    int acc;
    lat = 0; ex_a = '0; ex_fin = '0; ex_fout = '0;
    @(negedge clk);
    in_valid = 1'b1;
    wait_accept(tag, acc);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) begin
        ex_a = alu_a; ex_fin = alu_flags_in; ex_fout = alu_flags_out;
      end
      if (rf_wr_en && lat == 0) lat = k;
    end
  endtask

  int          lat;
  logic [31:0] ex_a;
  logic [3:0]  ex_fin, ex_fout;
  int          acc [3];
  int          wr_base;
  logic [31:0] exp_dat [3];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);

    preload(4'd0, 32'h55);
    preload(4'd1, 32'd5);
    preload(4'd2, 32'd7);
    preload(4'd5, 32'hAAAA);
    preload(4'd8, 32'hFFFF_FFFF);
    preload(4'd9, 32'd2);
    preload(4'd10, 32'd3);

    // Add r1+r2 -> r3, no flag commit
    set_instr(Alu_Add, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 1'b0);
    run_op("add", lat, ex_a, ex_fin, ex_fout);
    check("add_latency", lat, 32'd3);
    check("add_r3", mem[3], 32'd12);
    check("add_flags", {28'd0, flags}, 32'd0);
    check("add_alu_a_held", alu_a, 32'd5);

    // Add 0xFFFFFFFF + imm 1 -> r4, commit Z and C
    set_instr(Alu_Add, 4'd8, 4'd0, 4'd4, 1'b1, 32'd1, 1'b1);
    run_op("addi", lat, ex_a, ex_fin, ex_fout);
    check("addi_r4", mem[4], 32'd0);
    check("addi_exec_flags", {28'd0, ex_fout}, 32'h3);
    check("addi_flags", {28'd0, flags}, 32'h3);

    // Adc 2 + 3 + C -> r6
    set_instr(Alu_Adc, 4'd9, 4'd10, 4'd6, 1'b0, 32'd0, 1'b0);
    run_op("adc", lat, ex_a, ex_fin, ex_fout);
    check("adc_flags_in_c", {31'd0, ex_fin[FlagC]}, 32'd1);
    check("adc_r6", mem[6], 32'd6);

    // Three ops with in_valid held high throughout
    wr_base = wr_cnt;
    exp_dat[0] = 32'd12; exp_dat[1] = 32'd2; exp_dat[2] = 32'd7;
    @(negedge clk);
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      case (j)
        0: set_instr(Alu_Add, 4'd1, 4'd2, 4'd11, 1'b0, 32'd0, 1'b0);
        1: set_instr(Alu_Sub, 4'd2, 4'd1, 4'd12, 1'b0, 32'd0, 1'b0);
        default: set_instr(Alu_Or, 4'd1, 4'd2, 4'd13, 1'b0, 32'd0, 1'b0);
      endcase
      wait_accept("queue", acc[j]);
      if (j > 0) check("queue_interval", acc[j] - acc[j-1], 32'd4);
      check("queue_in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_wr_count", wr_cnt - wr_base, 32'd3);
    for (int j = 0; j < 3; j++) begin
      check("queue_wr_idx", {28'd0, wlog_idx[(wr_base + j) % 32]}, 32'd11 + j);
      check("queue_wr_dat", wlog_dat[(wr_base + j) % 32], exp_dat[j]);
    end
    check("queue_idle", {31'd0, busy}, 32'd0);

    // Reset during EXEC of an op targeting r5
    wr_base = wr_cnt;
    set_instr(Alu_Add, 4'd1, 4'd2, 4'd5, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    wait_accept("abort", acc[0]);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_flags", {28'd0, flags}, 32'd0);
    check("abort_wr_en", {31'd0, rf_wr_en}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_r5", mem[5], 32'hAAAA);
    check("abort_no_write", wr_cnt - wr_base, 32'd0);

    // Register 0 as a source and destination
    preload(4'd2, 32'd9);
    set_instr(Alu_Add, 4'd0, 4'd2, 4'd0, 1'b0, 32'd0, 1'b0);
    run_op("zero", lat, ex_a, ex_fin, ex_fout);
`ifdef ALU_ISSUE_ZERO_REG_EN
    check("zero_alu_a", ex_a, 32'd0);
    check("zero_latency", lat, 32'd0);
    check("zero_r0", mem[0], 32'h55);
`else
    check("zero_alu_a", ex_a, 32'h55);
    check("zero_latency", lat, 32'd3);
    check("zero_r0", mem[0], 32'h5E);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU interface: accepts one decoded ALU instruction per valid/ready handshake and reads its operands from the register file.
- Drives a/b/c/oper/flags_in to the combinational ALU, then captures out/flags_out.
- Writes the result back to the register file and, when enabled, updates the architectural flags register held in this block.
- Sits between the decode stage and the register file / ALU instance in the CPU core.

Parameters:
WORD_WIDTH, 32, data word width (matches CPU word).
FLAGS_WIDTH, 4, flags width, indices FlagZ/FlagC/FlagV/FlagN from pkg_cpu.
OPER_WIDTH, 5, ALU operation enum width.
REG_IDX_WIDTH, 4, register index width (16 GPRs).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  decoded instruction valid.
in_ready  out  1  block can accept an instruction.
in_oper  in  OPER_WIDTH  ALU operation.
in_ra_idx, in_rb_idx, in_rc_idx  in  REG_IDX_WIDTH each  source register indices.
in_rd_idx  in  REG_IDX_WIDTH  destination register index.
in_use_imm  in  1  1 = operand b comes from in_imm instead of rB.
in_imm  in  WORD_WIDTH  pre-extended immediate.
in_wr_flags  in  1  1 = commit ALU flags_out to the flags register.
rf_rd_idx_a, rf_rd_idx_b, rf_rd_idx_c  out  REG_IDX_WIDTH each  register file read addresses.
rf_rd_data_a, rf_rd_data_b, rf_rd_data_c  in  WORD_WIDTH each  read data, valid one cycle after the address is presented.
alu_a, alu_b, alu_c  out  WORD_WIDTH each  ALU operands.
alu_oper  out  OPER_WIDTH  ALU operation.
alu_flags_in  out  FLAGS_WIDTH  current flags register.
alu_out  in  WORD_WIDTH  ALU result, combinational.
alu_flags_out  in  FLAGS_WIDTH  ALU flags, combinational.
rf_wr_en  out  1  register file write strobe, one cycle.
rf_wr_idx  out  REG_IDX_WIDTH  write index.
rf_wr_data  out  WORD_WIDTH  write data.
flags  out  FLAGS_WIDTH  architectural flags register.
busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state = IDLE; flags = 0; rf_wr_en = 0.
  - All latched fields and result registers = 0.
  - in_ready = 1 in the first cycle after reset.
- States: IDLE, READ, EXEC, WB (enum st_alu_issue in pkg_cpu).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch all in_* fields, then go to READ.
  - Otherwise stay in IDLE.
- READ:
  - rf_rd_idx_* driven from the latched indices.
  - in_ready = 0; go to EXEC.
- EXEC:
  - rf_rd_data_* are valid in this cycle.
  - alu_a = rf_rd_data_a.
  - alu_b = latched use_imm ? latched imm : rf_rd_data_b.
  - alu_c = rf_rd_data_c.
  - alu_oper = latched oper; alu_flags_in = flags.
  - Register alu_out into res_data and alu_flags_out into res_flags; go to WB.
- WB:
  - rf_wr_en = 1, rf_wr_idx = latched rd, rf_wr_data = res_data.
  - At the end of this cycle, flags <= res_flags if latched wr_flags, else unchanged.
  - Go to IDLE.
- Outside EXEC, alu_* outputs hold the last latched values (no X). Outside READ, rf_rd_idx_* hold the latched indices.
- Timing:
  - Latency: accept edge to rf_wr_en high = 3 cycles.
  - Throughput: one instruction per 4 cycles.
  - flags visible on the output the cycle after WB.
- Handshake:
  - in_* fields are sampled only on the accept edge.
  - in_valid while in_ready = 0 is ignored. The producer must hold its instruction until it is accepted.
- Hazards: none in this block. Back-to-back instructions read the register file after the previous WB has completed.
- Reset mid-operation: rst in any state returns to IDLE next edge.
  - No rf_wr_en is issued for the aborted op.
  - flags is reset to 0.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.

Optional Feature:
ALU_ISSUE_ZERO_REG_EN
- Defined: register index 0 is hardwired to zero.
  - EXEC substitutes 0 for any operand whose latched source index is 0. This does not apply to b when use_imm = 1.
  - WB with rd = 0 keeps rf_wr_en = 0. The flags update still follows wr_flags.
- Undefined: index 0 is an ordinary register; reads and writes pass through unchanged.

Decomposition:
- pkg_cpu holds:
  - width constants;
  - flag index enum (FlagZ, FlagC, FlagV, FlagN);
  - ALU oper enum (Alu_Add=0, Alu_Adc=1, Alu_Sub=2, …);
  - st_alu_issue state enum.
- No sub-module: the ALU remains a separate instance wired by the core.
- The bench instantiates the real ALU plus a 16x32 synchronous-read register file model.

Test Plan:
- Reset, then one Alu_Add: r1=5, r2=7, rd=r3, wr_flags=0 → rf_wr_en exactly 3 cycles after the accept edge; r3=12; flags unchanged at 0.
- Alu_Add r1=0xFFFFFFFF, use_imm=1, imm=1, wr_flags=1 → r4=0x00000000, FlagC=1, flags matches the ALU flags_out captured in EXEC.
- Alu_Adc with flags FlagC=1 from the previous test, r1=2, r2=3 → alu_flags_in shows C=1, result 6.
- in_valid held high continuously with three queued ops → in_ready high only in IDLE; each op accepted once, every 4 cycles; results written in order.
- rst asserted in EXEC of an op targeting r5 (r5 initially 0xAAAA) → no rf_wr_en; r5 stays 0xAAAA; flags = 0; in_ready=1 next cycle.
- With ALU_ISSUE_ZERO_REG_EN: Alu_Add ra=0 (holding 0x55 in model), rb=r2=9, rd=0 → alu_a=0; no register write; repeat with the macro undefined → alu_a=0x55, r0 written 0x5E.
